countdown_timer: RTL



---
 rtl/countdown_timer_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 32 +++
 rtl/countdown_timer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss kitchen-timer countdown.
// Holds FSM state encodings, BCD digit width and the load clamp helper.
// No logic of its own; no latency or backpressure.
package countdown_timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v,
                                                   input logic [BCD_W-1:0] maxv);
        return (v > maxv) ? maxv : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps from 0 to MAXV and signals a borrow.
// Latency: digit updates one edge after load/dec_en; borrow is combinational.
// Backpressure: none, load wins over dec_en.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter int MAXV = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    output logic [BCD_W-1:0] digit,
    output logic             borrow
);

    localparam logic [BCD_W-1:0] MAXD = BCD_W'(MAXV);

    assign borrow = dec_en && (digit == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en) begin
            digit <= (digit == '0) ? MAXD : digit - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown with run/pause FSM, one-cycle done pulse and latched alarm.
// Latency: digits, done and running update on the edge that samples tick/control.
// Backpressure: none; tick is ignored outside RUN. COUNTDOWN_AUTO_RELOAD_EN adds reload-at-expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_mt,
    input  logic [BCD_W-1:0] ld_mo,
    input  logic [BCD_W-1:0] ld_st,
    input  logic [BCD_W-1:0] ld_so,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    output logic [BCD_W-1:0] mt,
    output logic [BCD_W-1:0] mo,
    output logic [BCD_W-1:0] st,
    output logic [BCD_W-1:0] so,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam logic [BCD_W-1:0] MT_MAX = BCD_W'(MIN_TENS_MAX);
    localparam logic [BCD_W-1:0] ST_MAX = BCD_W'(SEC_TENS_MAX);

    state_t state, state_nxt;

    logic [4*BCD_W-1:0] clamped;
    logic [4*BCD_W-1:0] load_dat;
    logic               load_acc;
    logic               dec;
    logic               expire;
    logic               reload;
    logic               digit_load;
    logic               count_nz;
    logic               so_borrow, st_borrow, mo_borrow, mt_borrow;

    assign clamped  = {bcd_clamp(ld_mt, MT_MAX), bcd_clamp(ld_mo, BCD_NINE),
                       bcd_clamp(ld_st, ST_MAX), bcd_clamp(ld_so, BCD_NINE)};
    assign load_acc = load && (state == ST_IDLE || state == ST_PAUSE);
    assign dec      = (state == ST_RUN) && tick && !stop;
    assign count_nz = |{mt, mo, st, so};
    assign expire   = dec && ({mt, mo, st} == '0) && (so == 4'd1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [4*BCD_W-1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (load_acc) begin
            shadow <= clamped;
        end
    end

    // A zero shadow means nothing to reload, so expiry behaves normally.
    assign reload   = expire && (shadow != '0);
    assign load_dat = reload ? shadow : clamped;
`else
    assign reload   = 1'b0;
    assign load_dat = clamped;
`endif

    assign digit_load = load_acc || reload;

    bcd_down_digit #(.MAXV(9)) u_so (
        .clk(clk), .reset(reset), .load(digit_load), .load_val(load_dat[3:0]),
        .dec_en(dec), .digit(so), .borrow(so_borrow)
    );
    bcd_down_digit #(.MAXV(SEC_TENS_MAX)) u_st (
        .clk(clk), .reset(reset), .load(digit_load), .load_val(load_dat[7:4]),
        .dec_en(so_borrow), .digit(st), .borrow(st_borrow)
    );
    bcd_down_digit #(.MAXV(9)) u_mo (
        .clk(clk), .reset(reset), .load(digit_load), .load_val(load_dat[11:8]),
        .dec_en(st_borrow), .digit(mo), .borrow(mo_borrow)
    );
    bcd_down_digit #(.MAXV(MIN_TENS_MAX)) u_mt (
        .clk(clk), .reset(reset), .load(digit_load), .load_val(load_dat[15:12]),
        .dec_en(mo_borrow), .digit(mt), .borrow(mt_borrow)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!load && start && count_nz) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop)                  state_nxt = ST_PAUSE;
                else if (expire && !reload) state_nxt = ST_EXPIRED;
            end
            ST_PAUSE: begin
                if (load)       state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_RUN;
            end
            ST_EXPIRED: begin
                if (ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= expire;
        end
    end

    assign alarm = (state == ST_EXPIRED);

    // mt_borrow would mean decrementing past 00:00, which expiry prevents.
    logic unused_borrow;
    assign unused_borrow = mt_borrow;

endmodule
